// File: rtl/numeruesi_programit_pkg.sv
// Shared definitions for the program counter sequencer: state encoding and
// default address width.
package numeruesi_programit_pkg;

  localparam int unsigned DEFAULT_AW = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_HALTED = 2'b10
  } state_e;

endpackage : numeruesi_programit_pkg

// File: rtl/numeruesi_programit_mux_2ne1_n.sv
// N-bit wide 2-to-1 vector multiplexer; sel_i=1 selects b_i.
module mux_2ne1_n #(
  parameter int unsigned N = 8
) (
  input  logic         sel_i,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] y_o
);

  assign y_o = sel_i ? b_i : a_i;

endmodule : mux_2ne1_n

// File: rtl/numeruesi_programit.sv
// Program counter sequencer: IDLE/RUN/HALTED control with start, stall, halt,
// absolute jump and PC-relative branch; next PC chosen through a mux chain.
module numeruesi_programit
  import numeruesi_programit_pkg::*;
#(
  parameter int unsigned AW         = DEFAULT_AW,
  parameter int unsigned START_ADDR = 0
) (
  input  logic          Clock,
  input  logic          Reset_n,
  input  logic          Start,
  input  logic          Stall,
  input  logic          Halt,
  input  logic          Jump,
  input  logic [AW-1:0] JumpAddr,
  input  logic          Branch,
  input  logic [AW-1:0] BranchOffset,
  output logic [AW-1:0] PC,
  output logic [AW-1:0] PC_Plus1,
  output logic          Running,
  output logic          Done,
  output logic [1:0]    DbgState
);

  localparam logic [AW-1:0] START_PC = AW'(START_ADDR);
  localparam logic [AW-1:0] PC_ONE   = AW'(1);

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;

  logic [AW-1:0] pc_plus1;
  logic [AW-1:0] pc_branch;
  logic [AW-1:0] pc_seq;
  logic [AW-1:0] pc_flow;
  logic [AW-1:0] pc_target;
  logic          advance;

  // Sums are AW bits wide so carries fall off: wrap-around is intended.
  assign pc_plus1  = pc_q + PC_ONE;
  assign pc_branch = pc_plus1 + BranchOffset;

  mux_2ne1_n #(.N(AW)) u_mux_branch (
    .sel_i (Branch),
    .a_i   (pc_plus1),
    .b_i   (pc_branch),
    .y_o   (pc_seq)
  );

  mux_2ne1_n #(.N(AW)) u_mux_jump (
    .sel_i (Jump),
    .a_i   (pc_seq),
    .b_i   (JumpAddr),
    .y_o   (pc_flow)
  );

  mux_2ne1_n #(.N(AW)) u_mux_start (
    .sel_i (Start),
    .a_i   (pc_flow),
    .b_i   (START_PC),
    .y_o   (pc_target)
  );

  // A halt or stall in RUN freezes the PC; Start overrides every other control.
  assign advance = (state_q == ST_RUN) && !Stall && !Halt;

  always_comb begin
    pc_d = pc_q;
    if (Start || advance) begin
      pc_d = pc_target;
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_IDLE;
      pc_q    <= START_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (Start) begin
      state_d = ST_RUN;
    end else begin
      unique case (state_q)
        ST_IDLE:   state_d = ST_IDLE;
        ST_RUN:    state_d = (!Stall && Halt) ? ST_HALTED : ST_RUN;
        ST_HALTED: state_d = ST_HALTED;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    Running  = (state_q == ST_RUN);
    Done     = (state_q == ST_HALTED);
    DbgState = state_q;
    PC       = pc_q;
    PC_Plus1 = pc_plus1;
  end

endmodule : numeruesi_programit

// File: tb/tb_numeruesi_programit.sv
// Bench for numeruesi_programit: directed vector table, reset corner sequence
// and a randomised tail checked against a reference model through a queue.
module tb_numeruesi_programit;

  localparam int AW = 8;
  localparam int W  = AW + 2;

  typedef struct {
    string      name;
    logic       start;
    logic       stall;
    logic       halt;
    logic       jump;
    logic [7:0] jaddr;
    logic       branch;
    logic [7:0] boff;
    logic [7:0] exp_pc;
    logic       exp_run;
    logic       exp_done;
  } vec_t;

  logic          Clock = 1'b0;
  logic          Reset_n;
  logic          Start, Stall, Halt, Jump, Branch;
  logic [AW-1:0] JumpAddr, BranchOffset;
  logic [AW-1:0] PC, PC_Plus1;
  logic          Running, Done;
  logic [1:0]    DbgState;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  vec_t vecs[$];

  logic [7:0] m_pc;
  logic [1:0] m_st;

  always #5 Clock = ~Clock;

  numeruesi_programit #(.AW(AW), .START_ADDR(0)) dut (
    .Clock        (Clock),
    .Reset_n      (Reset_n),
    .Start        (Start),
    .Stall        (Stall),
    .Halt         (Halt),
    .Jump         (Jump),
    .JumpAddr     (JumpAddr),
    .Branch       (Branch),
    .BranchOffset (BranchOffset),
    .PC           (PC),
    .PC_Plus1     (PC_Plus1),
    .Running      (Running),
    .Done         (Done),
    .DbgState     (DbgState)
  );

  function automatic vec_t mk(input string name, input logic st, input logic sl,
                              input logic h, input logic j, input logic [7:0] ja,
                              input logic b, input logic [7:0] bo,
                              input logic [7:0] ep, input logic er, input logic ed);
    vec_t v;
    v.name = name; v.start = st; v.stall = sl; v.halt = h; v.jump = j;
    v.jaddr = ja; v.branch = b; v.boff = bo;
    v.exp_pc = ep; v.exp_run = er; v.exp_done = ed;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [7:0] pc,
                             input logic run, input logic done);
    logic [7:0] p1;
    p1 = pc + 8'd1;
    check({tag, ".PC"},       32'(PC),       32'(pc));
    check({tag, ".PC_Plus1"}, 32'(PC_Plus1), 32'(p1));
    check({tag, ".Running"},  32'(Running),  32'(run));
    check({tag, ".Done"},     32'(Done),     32'(done));
    check({tag, ".State"},    32'(DbgState), 32'({done, run}));
  endtask

  task automatic compare_pop(input string tag);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty, got PC 0x%0h", tag, PC);
    end else begin
      e = exp_q.pop_front();
      check_state(tag, e[AW-1:0], e[W-1], e[W-2]);
    end
  endtask

  task automatic drive(input logic st, input logic sl, input logic h, input logic j,
                       input logic [7:0] ja, input logic b, input logic [7:0] bo);
    Start = st; Stall = sl; Halt = h; Jump = j;
    JumpAddr = ja; Branch = b; BranchOffset = bo;
  endtask

  task automatic step(input vec_t v);
    @(negedge Clock);
    drive(v.start, v.stall, v.halt, v.jump, v.jaddr, v.branch, v.boff);
    exp_q.push_back({v.exp_run, v.exp_done, v.exp_pc});
    @(posedge Clock);
    #1;
    compare_pop(v.name);
  endtask

  initial begin
    vec_t v;
    Reset_n = 1'b0;
    drive(0, 0, 0, 0, 8'h00, 0, 8'h00);

    // Reset state
    repeat (2) @(posedge Clock);
    #1;
    check_state("reset", 8'h00, 0, 0);
    @(negedge Clock);
    Reset_n = 1'b1;

    //          name           st sl h  j  jaddr  b  boff   pc     run done
    vecs.push_back(mk("idle_hold",   0, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0));
    vecs.push_back(mk("start",       1, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 1, 0));
    vecs.push_back(mk("free1",       0, 0, 0, 0, 8'h00, 0, 8'h00, 8'h01, 1, 0));
    vecs.push_back(mk("free2",       0, 0, 0, 0, 8'h00, 0, 8'h00, 8'h02, 1, 0));
    vecs.push_back(mk("free3",       0, 0, 0, 0, 8'h00, 0, 8'h00, 8'h03, 1, 0));
    vecs.push_back(mk("free4",       0, 0, 0, 0, 8'h00, 0, 8'h00, 8'h04, 1, 0));
    vecs.push_back(mk("free5",       0, 0, 0, 0, 8'h00, 0, 8'h00, 8'h05, 1, 0));
    vecs.push_back(mk("br_neg",      0, 0, 0, 0, 8'h00, 1, 8'hFD, 8'h03, 1, 0));
    vecs.push_back(mk("jmp5",        0, 0, 0, 1, 8'h05, 0, 8'h00, 8'h05, 1, 0));
    vecs.push_back(mk("br_pos",      0, 0, 0, 0, 8'h00, 1, 8'h04, 8'h0A, 1, 0));
    vecs.push_back(mk("jmp7",        0, 0, 0, 1, 8'h07, 0, 8'h00, 8'h07, 1, 0));
    vecs.push_back(mk("jmp_pri",     0, 0, 0, 1, 8'h40, 1, 8'h04, 8'h40, 1, 0));
    vecs.push_back(mk("jmpFF",       0, 0, 0, 1, 8'hFF, 0, 8'h00, 8'hFF, 1, 0));
    vecs.push_back(mk("wrap",        0, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 1, 0));
    vecs.push_back(mk("br_to_FF",    0, 0, 0, 0, 8'h00, 1, 8'hFE, 8'hFF, 1, 0));
    vecs.push_back(mk("br_wrap",     0, 0, 0, 0, 8'h00, 1, 8'h01, 8'h01, 1, 0));
    vecs.push_back(mk("jmp9",        0, 0, 0, 1, 8'h09, 0, 8'h00, 8'h09, 1, 0));
    vecs.push_back(mk("stall_halt1", 0, 1, 1, 1, 8'h22, 1, 8'h05, 8'h09, 1, 0));
    vecs.push_back(mk("stall_halt2", 0, 1, 1, 0, 8'h00, 0, 8'h00, 8'h09, 1, 0));
    vecs.push_back(mk("halt_pri",    0, 0, 1, 1, 8'h33, 1, 8'h05, 8'h09, 0, 1));
    vecs.push_back(mk("halted_hold", 0, 0, 0, 0, 8'h00, 0, 8'h00, 8'h09, 0, 1));
    vecs.push_back(mk("halted_jmp",  0, 0, 0, 1, 8'h33, 1, 8'h02, 8'h09, 0, 1));
    vecs.push_back(mk("start_halt",  1, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 1, 0));
    vecs.push_back(mk("free_a",      0, 0, 0, 0, 8'h00, 0, 8'h00, 8'h01, 1, 0));
    vecs.push_back(mk("restart_pri", 1, 1, 1, 1, 8'h55, 1, 8'h07, 8'h00, 1, 0));
    vecs.push_back(mk("free_b",      0, 0, 0, 0, 8'h00, 0, 8'h00, 8'h01, 1, 0));
    vecs.push_back(mk("jmp12",       0, 0, 0, 1, 8'h12, 0, 8'h00, 8'h12, 1, 0));

    foreach (vecs[i]) step(vecs[i]);

    // Asynchronous reset in the middle of a clock phase, mid-RUN at PC=0x12
    @(negedge Clock);
    drive(0, 0, 0, 0, 8'h00, 0, 8'h00);
    #2;
    Reset_n = 1'b0;
    #1;
    check_state("rst_async", 8'h00, 0, 0);
    @(posedge Clock);
    #1;
    check_state("rst_held", 8'h00, 0, 0);
    @(negedge Clock);
    Reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(mk("post_rst_idle", 0, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0));
    end
    step(mk("post_rst_start", 1, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 1, 0));
    step(mk("post_rst_free",  0, 0, 0, 0, 8'h00, 0, 8'h00, 8'h01, 1, 0));

    // Randomised tail against a reference model (state: 0 idle, 1 run, 2 halted)
    m_pc = 8'h01;
    m_st = 2'd1;
    for (int k = 0; k < 80; k++) begin
      v = mk("rand", ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) == 0),
             8'($urandom_range(0, 255)), ($urandom_range(0, 2) == 0),
             8'($urandom_range(0, 255)), 8'h00, 0, 0);
      if (v.start) begin
        m_pc = 8'h00;
        m_st = 2'd1;
      end else if (m_st == 2'd1 && !v.stall) begin
        if (v.halt)        m_st = 2'd2;
        else if (v.jump)   m_pc = v.jaddr;
        else if (v.branch) m_pc = m_pc + 8'd1 + v.boff;
        else               m_pc = m_pc + 8'd1;
      end
      v.exp_pc   = m_pc;
      v.exp_run  = (m_st == 2'd1);
      v.exp_done = (m_st == 2'd2);
      step(v);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_numeruesi_programit
